// File: rtl/alu_pkg.sv
// Shared ALU definitions: serial FSM states, add/sub select encodings,
// the signed-overflow rule and the saturation-value helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  localparam int unsigned SAT_MAX_W = 64;

  // Same sign rule as the combinational ALU overflow detector
  function automatic logic ovf_detect(input logic binv, input logic sa,
                                      input logic sb, input logic r);
    return (~binv & ~sa & ~sb &  r) |
           (~binv &  sa &  sb & ~r) |
           ( binv & ~sa &  sb &  r) |
           ( binv &  sa & ~sb & ~r);
  endfunction

  // A wrapped sign of 1 on overflow means the true result was positive
  function automatic logic [SAT_MAX_W-1:0] sat_value(input logic res_sign,
                                                     input int unsigned w);
    logic [SAT_MAX_W-1:0] msb;
    msb = SAT_MAX_W'(1) << (w - 1);
    return res_sign ? (msb - SAT_MAX_W'(1)) : msb;
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Start/busy/done handshake and operand/result bus of the serial add/sub unit.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             binvert;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, binvert, a, b,
    input  busy, done, result, overflow, carry_out
  );

  modport slave (
    input  start, binvert, a, b,
    output busy, done, result, overflow, carry_out
  );

endinterface

// File: rtl/full_adder_bit.sv
// One-bit full adder used as the serial add/sub datapath slice.
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum_c,
  output logic carry_c
);

  assign sum_c   = x ^ y ^ cin;
  assign carry_c = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial signed adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_addsub_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e state_q, state_d;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load, shift_en, fin;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry_q;
  logic             sign_a_q, sign_b_q, binv_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] result_q;
  logic             ovf_q;
  logic             cout_q;

  logic             fa_sum_c, fa_carry_c;
  logic             ovf_c;
  logic [WIDTH-1:0] fin_result_c;

  full_adder_bit u_fa (
    .x       (a_sr[0]),
    .y       (b_sr[0]),
    .cin     (carry_q),
    .sum_c   (fa_sum_c),
    .carry_c (fa_carry_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start seen while done is still high is dropped; the next IDLE cycle accepts
  always_comb begin
    state_d  = state_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    shift_en = 1'b0;
    fin      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && !done_q) begin
          load    = 1'b1;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIN;
        end else begin
          busy_d = 1'b1;
        end
      end
      FIN: begin
        fin     = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ovf_c = ovf_detect(binv_q, sign_a_q, sign_b_q, res_sr[WIDTH-1]);

`ifdef SERIAL_ADDSUB_SAT_EN
  assign fin_result_c = ovf_c ? WIDTH'(sat_value(res_sr[WIDTH-1], WIDTH)) : res_sr;
`else
  assign fin_result_c = res_sr;
`endif

  // Operand/result shift registers, bit counter and held outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry_q  <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      binv_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (load) begin
        a_sr     <= bus.a;
        b_sr     <= bus.b ^ {WIDTH{bus.binvert}};
        res_sr   <= '0;
        carry_q  <= bus.binvert;
        sign_a_q <= bus.a[WIDTH-1];
        sign_b_q <= bus.b[WIDTH-1];
        binv_q   <= bus.binvert;
        cnt_q    <= '0;
      end else if (shift_en) begin
        a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
        res_sr  <= {fa_sum_c, res_sr[WIDTH-1:1]};
        carry_q <= fa_carry_c;
        cnt_q   <= cnt_q + CNT_W'(1);
      end
      if (fin) begin
        result_q <= fin_result_c;
        ovf_q    <= ovf_c;
        cout_q   <= carry_q;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: arithmetic/timing model plus directed vectors.
module tb_serial_addsub;
  import alu_pkg::*;

  localparam int W = 8;

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [7:0] E_100P50  = 8'h7F;
  localparam logic [7:0] E_M128M1  = 8'h80;
  localparam logic [7:0] E_7FM80   = 8'h7F;
  localparam logic [7:0] E_M128PM128 = 8'h80;
`else
  localparam logic [7:0] E_100P50  = 8'h96;
  localparam logic [7:0] E_M128M1  = 8'h7F;
  localparam logic [7:0] E_7FM80   = 8'hFF;
  localparam logic [7:0] E_M128PM128 = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mon_on = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  serial_addsub_if #(.WIDTH(W)) bus ();

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Packed as {overflow, carry_out, result}, from signed/unsigned arithmetic
  function automatic logic [W+1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic binv);
    int sa, sb, tr, ua, ub;
    logic ovf, cy;
    logic [W-1:0] res;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ua  = int'(a);
    ub  = int'(b);
    tr  = binv ? (sa - sb) : (sa + sb);
    ovf = (tr > (2 ** (W - 1)) - 1) || (tr < -(2 ** (W - 1)));
    cy  = binv ? (ua >= ub) : ((ua + ub) >= (2 ** W));
    res = W'(tr);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (ovf) res = (tr > 0) ? W'((2 ** (W - 1)) - 1) : W'(2 ** (W - 1));
`endif
    return {ovf, cy, res};
  endfunction

  // Transaction model: age counts edges since the accepting edge
  int             age = -1;
  logic [W+1:0]   pend = '0;
  logic [W-1:0]   m_res = '0;
  logic           m_ovf = 1'b0;
  logic           m_cy = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age   <= -1;
      m_res <= '0;
      m_ovf <= 1'b0;
      m_cy  <= 1'b0;
    end else if (age == W + 1) begin
      age <= -1;
    end else if (age < 0) begin
      if (bus.start === 1'b1) begin
        age  <= 0;
        pend <= model_op(bus.a, bus.b, bus.binvert);
      end
    end else begin
      age <= age + 1;
      if (age == W) {m_ovf, m_cy, m_res} <= pend;
    end
  end

  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      chk("mon_busy", 32'(bus.busy), 32'(age >= 0 && age < W));
      chk("mon_done", 32'(bus.done), 32'(age == W + 1));
      chk("mon_result", 32'(bus.result), 32'(m_res));
      chk("mon_overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("mon_carry", 32'(bus.carry_out), 32'(m_cy));
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic binv,
                        input logic [7:0] er, input logic eo, input logic ec, input string nm);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.binvert = binv; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      chk({nm, "_timeout"}, 32'(bus.done), 32'(1));
    end else begin
      chk({nm, "_result"}, 32'(bus.result), 32'(er));
      chk({nm, "_overflow"}, 32'(bus.overflow), 32'(eo));
      chk({nm, "_carry"}, 32'(bus.carry_out), 32'(ec));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.binvert = 1'b0; bus.a = '0; bus.b = '0;
    #1 rst_n = 1'b0;
    #1 mon_on = 1'b1;

    chk("pin_100p50", 32'(model_op(8'd100, 8'd50, ALU_OP_ADD)), 32'({1'b1, 1'b0, E_100P50}));
    chk("pin_m128m1", 32'(model_op(8'h80, 8'h01, ALU_OP_SUB)), 32'({1'b1, 1'b1, E_M128M1}));

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_result", 32'(bus.result), 32'(0));
    chk("rst_overflow", 32'(bus.overflow), 32'(0));
    chk("rst_carry", 32'(bus.carry_out), 32'(0));
    #2 rst_n = 1'b1;

    run_op(8'd100, 8'd50, ALU_OP_ADD, E_100P50, 1'b1, 1'b0, "add_100_50");
    run_op(8'd50, 8'd100, ALU_OP_SUB, 8'hCE, 1'b0, 1'b0, "sub_50_100");
    run_op(8'h80, 8'h01, ALU_OP_SUB, E_M128M1, 1'b1, 1'b1, "sub_m128_1");
    run_op(8'h80, 8'h80, ALU_OP_ADD, E_M128PM128, 1'b1, 1'b1, "add_m128_m128");

    // Timing, start during busy, start coincident with done, back-to-back
    @(negedge clk);
    bus.a = 8'h7F; bus.b = 8'h80; bus.binvert = ALU_OP_SUB; bus.start = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      chk("tim_busy", 32'(bus.busy), 32'((c >= 1 && c <= 8) || (c >= 12 && c <= 19)));
      chk("tim_done", 32'(bus.done), 32'(c == 10 || c == 21));
      if (c == 10) begin
        chk("tim_7fm80_result", 32'(bus.result), 32'(E_7FM80));
        chk("tim_7fm80_overflow", 32'(bus.overflow), 32'(1));
        chk("tim_7fm80_carry", 32'(bus.carry_out), 32'(0));
        bus.a = 8'hFF; bus.b = 8'h01; bus.binvert = ALU_OP_ADD; bus.start = 1'b1;
      end
      if (c == 21) begin
        chk("b2b_ff_1_result", 32'(bus.result), 32'(8'h00));
        chk("b2b_ff_1_overflow", 32'(bus.overflow), 32'(0));
        chk("b2b_ff_1_carry", 32'(bus.carry_out), 32'(1));
      end
      case (c)
        1:  bus.start = 1'b0;
        3:  bus.start = 1'b1;
        4:  bus.start = 1'b0;
        12: bus.start = 1'b0;
        default: ;
      endcase
    end

    // Reset in the middle of SHIFT aborts with no done pulse
    run_op(8'd50, 8'd100, ALU_OP_SUB, 8'hCE, 1'b0, 1'b0, "pre_rst_sub");
    @(negedge clk);
    bus.a = 8'h80; bus.b = 8'h01; bus.binvert = ALU_OP_SUB; bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    chk("mid_busy_pre", 32'(bus.busy), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'(0));
    chk("mid_rst_done", 32'(bus.done), 32'(0));
    chk("mid_rst_result", 32'(bus.result), 32'(0));
    chk("mid_rst_overflow", 32'(bus.overflow), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("mid_rst_no_done", 32'(bus.done), 32'(0));
    run_op(8'd100, 8'd50, ALU_OP_ADD, E_100P50, 1'b1, 1'b0, "post_rst_add");
    run_op(8'd7, 8'd9, ALU_OP_SUB, 8'hFE, 1'b0, 1'b0, "sub_7_9");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial signed adder/subtractor. Processes one bit per clock, LSB first, and flags two's-complement overflow at the MSB.
- Sits beside the combinational ALU. It is the low-area producer of result and sign bits; its overflow output uses the same sign rule as the ALU overflow detector: add overflows when the operands have equal signs and the result sign differs; sub overflows when a and b have different signs and the result sign differs from a.
- Start/busy/done handshake toward the control unit.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2); MSB is the sign bit.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  request; sampled only in IDLE
- binvert  in  1  0 = a+b, 1 = a−b (b inverted, carry-in = 1)
- a  in  WIDTH  operand a, sampled with start
- b  in  WIDTH  operand b, sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result/overflow/carry_out valid
- result  out  WIDTH  sum/difference, held until next accepted start
- overflow  out  1  signed overflow of last operation, held
- carry_out  out  1  carry out of MSB (unsigned carry / no-borrow), held

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, result=0, overflow=0, carry_out=0, bit counter=0, internal registers=0. Reset mid-operation aborts the operation and produces no done pulse.
- States:
  - IDLE: on start=1 latch a into shift reg A, b^{WIDTH{binvert}} into shift reg B, carry=binvert, sign_a=a[MSB], sign_b=b[MSB], latched binvert, count=0 → SHIFT.
  - SHIFT: each cycle compute s = A[0]^B[0]^carry and carry = majority(A[0],B[0],carry). Shift A and B right, shift s into result-shift MSB, count++. When count==WIDTH−1 → FIN.
  - FIN: done=1 for exactly one cycle; result, overflow and carry_out registered; → IDLE.
- Latency: start accepted at edge k; SHIFT occupies edges k+1..k+WIDTH; done high in the cycle after edge k+WIDTH+1. That is WIDTH+2 edges from start to done visible, with busy high for WIDTH cycles.
- overflow = (~binv & ~sa & ~sb & r) | (~binv & sa & sb & ~r) | (binv & ~sa & sb & r) | (binv & sa & ~sb & ~r), where r = final result sign. Both add directions are covered.
- start while busy or in FIN: ignored, no queuing. start coincident with done: ignored, must be reissued in IDLE.
- result, overflow and carry_out are updated only in FIN. They are stable in IDLE and during the next operation until its FIN.
- Width rules: result wraps modulo 2^WIDTH. Counter width = $clog2(WIDTH).

Optional Feature:
- Macro SERIAL_ADDSUB_SAT_EN.
- Defined: when overflow=1, result saturates in FIN: positive overflow (r=1 with non-negative true result) → 0111…1; negative overflow → 1000…0. overflow and carry_out still report the raw condition.
- Undefined: result is the wrapped value.

Decomposition:
- Shared package alu_pkg: state enum (IDLE, SHIFT, FIN), ALU_OP_ADD/ALU_OP_SUB binvert constants, a saturation-value function.
- Natural sub-module: full_adder_bit (1-bit sum/carry).
- The overflow equation is reused from the existing ALU overflow detector; do not re-derive it.

Test Plan:
- WIDTH=8, a=100, b=50, binvert=0 → result=0x96, overflow=1, carry_out=0; with SAT_EN result=0x7F.
- a=50, b=100, binvert=1 → result=0xCE (−50), overflow=0, carry_out=0.
- a=0x80 (−128), b=1, binvert=1 → result=0x7F, overflow=1, carry_out=1; with SAT_EN result=0x80.
- Timing: start pulse at cycle 0 → busy high for 8 cycles, done single pulse at cycle 10; a second start during busy produces no second done.
- a=0xFF, b=0x01, binvert=0 → result=0x00, overflow=0, carry_out=1. Back-to-back start in the first IDLE cycle after done is accepted.
- Assert rst_n=0 at SHIFT count=3 → busy=0, done=0, result=0 immediately. Next start after release completes normally.
